// File: rtl/bias_accum_relu.sv
// rtl/bias_accum_relu.sv - per-lane bias + partial-sum accumulator with ReLU and 18-bit saturation
module bias_accum_relu #(
    parameter int N_adder_tree = 16,
    parameter int N_PASS       = 4,
    parameter int ACC_W        = 24,
    parameter int N_GROUP      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_adder_tree*18-1:0] bias,
    input  logic [N_adder_tree*18-1:0] in_sum,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_adder_tree*18-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int PW = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(N_PASS - 1);
    localparam logic [GW-1:0] G_LAST = GW'(N_GROUP - 1);

    logic [PW-1:0] pcnt;
    logic [GW-1:0] gcnt;
    logic          out_valid_q;
    logic          accept;
    logic          final_beat;
    logic          out_xfer;

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign final_beat = accept && (pcnt == P_LAST);
    assign out_xfer   = out_valid_q && out_ready;
    assign out_valid  = out_valid_q;
    assign out_last   = (gcnt == G_LAST) && out_valid_q;

    // Pass/group counters and output-valid flag; a new final beat on a transfer edge keeps valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt        <= '0;
            gcnt        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
            end
            if (out_xfer) begin
                gcnt <= (gcnt == G_LAST) ? '0 : gcnt + 1'b1;
            end
            if (final_beat) begin
                out_valid_q <= 1'b1;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] base;
        logic signed [ACC_W-1:0] nxt;
        logic        [17:0]      res;
        logic        [17:0]      od;

        // First beat of a vector starts from the bias; later beats continue the running sum
        assign base = (pcnt == '0) ? {{(ACC_W-18){bias[18*i+17]}}, bias[18*i +: 18]} : acc;
        assign nxt  = base + {{(ACC_W-18){in_sum[18*i+17]}}, in_sum[18*i +: 18]};

        // ReLU clamps negatives to 0; any set bit above bit 16 of a positive sum saturates to 131071
        assign res = nxt[ACC_W-1]        ? 18'd0 :
                     (|nxt[ACC_W-2:17])  ? 18'h1FFFF :
                                           nxt[17:0];

        // Lane accumulator and output register; output only reloads on the final beat
        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
                od  <= '0;
            end else begin
                if (accept) begin
                    acc <= nxt;
                end
                if (final_beat) begin
                    od <= res;
                end
            end
        end

        assign out_data[18*i +: 18] = od;
    end

endmodule

// File: tb/tb_bias_accum_relu.sv
// tb/tb_bias_accum_relu.sv - randomized and directed self-checking bench for bias_accum_relu
module tb_bias_accum_relu;

    localparam int N  = 16;
    localparam int NP = 4;
    localparam int NG = 8;
    localparam int W  = N * 18;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] bias;
    logic [W-1:0] in_sum;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    int errors = 0;
    int checks = 0;

    // reference state: running sums as plain integers, count of beats in the current vector
    int           m_acc [N];
    int           m_cnt;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_g;

    always #5 clk = ~clk;

    bias_accum_relu #(
        .N_adder_tree(N),
        .N_PASS      (NP),
        .ACC_W       (24),
        .N_GROUP     (NG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bias     (bias),
        .in_sum   (in_sum),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 131071) return 131071;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_g     = 0;
    endtask

    // One clock: check DUT against the model at the negedge, then advance the model across the posedge
    task automatic cycle();
        bit ir;
        bit take_in;
        bit take_out;
        @(negedge clk);
        ir = !m_valid || out_ready;
        check("in_ready", W'(in_ready), W'(ir));
        check("out_valid", W'(out_valid), W'(m_valid));
        check("out_last", W'(out_last), W'(m_valid && (m_g == NG - 1)));
        if (m_valid) check("out_data", out_data, m_data);
        if (rst) begin
            model_reset();
        end else begin
            take_out = m_valid && out_ready;
            take_in  = in_valid && ir;
            if (take_out) begin
                m_g     = (m_g + 1) % NG;
                m_valid = 1'b0;
            end
            if (take_in) begin
                for (int i = 0; i < N; i++) begin
                    int b = $signed(bias[18*i +: 18]);
                    int s = $signed(in_sum[18*i +: 18]);
                    if (m_cnt == 0) m_acc[i] = b;
                    m_acc[i] = m_acc[i] + s;
                end
                m_cnt++;
                if (m_cnt == NP) begin
                    m_cnt   = 0;
                    m_valid = 1'b1;
                    for (int i = 0; i < N; i++) m_data[18*i +: 18] = 18'(clamp(m_acc[i]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input int b);
        for (int i = 0; i < N; i++) bias[18*i +: 18] = 18'(b);
    endtask

    task automatic beat(input int s);
        for (int i = 0; i < N; i++) in_sum[18*i +: 18] = 18'(s);
        in_valid = 1'b1;
        cycle();
    endtask

    task automatic check_lane0(input string tag, input int exp);
        check(tag, W'(out_data[17:0]), W'(18'(exp)));
    endtask

    // Full vector with identical beats on every lane, then one idle cycle to drain
    task automatic vector(input string tag, input int b, input int s, input int exp);
        set_bias(b);
        for (int k = 0; k < NP; k++) beat(s);
        check_lane0(tag, exp);
        check({tag, "_valid"}, W'(out_valid), W'(1'b1));
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        bias      = '0;
        in_sum    = '0;
        for (int i = 0; i < N; i++) in_sum[18*i +: 18] = 18'($urandom);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_data", out_data, '0);
        check("rst_valid", W'(out_valid), W'(1'b0));
        rst      = 1'b0;
        in_valid = 1'b0;
        check("ready_after_rst", W'(in_ready), W'(1'b1));

        // basic path: 4 + 10 + 20 + 30 + 40
        set_bias(4);
        beat(10);
        beat(20);
        beat(30);
        beat(40);
        check_lane0("basic", 104);
        check("basic_valid", W'(out_valid), W'(1'b1));
        in_valid = 1'b0;
        cycle();
        check("basic_pulse", W'(out_valid), W'(1'b0));

        vector("relu", -1000, -5, 0);
        vector("sat", 131071, 131071, 131071);
        vector("negwrap", -131072, -131072, 0);

        // backpressure: stall with an output held and a beat offered
        set_bias(7);
        for (int k = 1; k <= NP; k++) beat(k);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) in_sum[18*i +: 18] = 18'($urandom);
            in_valid = 1'b1;
            cycle();
        end
        check("bp_ready", W'(in_ready), W'(1'b0));
        check_lane0("bp_hold", 17);
        out_ready = 1'b1;
        for (int k = 0; k < 3 * NP; k++) beat(100 + k);
        in_valid = 1'b0;
        repeat (2) cycle();

        // reset mid-vector abandons the partial sum and restarts the group count
        set_bias(50);
        beat(9);
        beat(9);
        rst = 1'b1;
        beat(9);
        rst = 1'b0;
        beat(1);
        beat(2);
        beat(3);
        beat(4);
        check_lane0("rst_mid", 60);
        check("rst_mid_last", W'(out_last), W'(1'b0));
        for (int v = 2; v <= NG; v++) begin
            for (int k = 0; k < NP; k++) beat(v);
            if (v == NG) check("last8", W'(out_last), W'(1'b1));
            else         check("not_last", W'(out_last), W'(1'b0));
        end
        in_valid = 1'b0;
        cycle();

        // randomized traffic with gaps, backpressure, bias changes and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 53 == 0) begin
                for (int i = 0; i < N; i++) bias[18*i +: 18] = 18'($urandom);
            end
            for (int i = 0; i < N; i++) in_sum[18*i +: 18] = 18'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bias_accum_relu.md
BIAS_ACCUM_RELU -- requirements
Module: bias_accum_relu

Interface
REQ-001 Parameter N_adder_tree, 16, number of parallel output-channel lanes.
REQ-002 Parameter N_PASS, 4, partial-sum beats accumulated per output vector (legal range 1..64).
REQ-003 Parameter ACC_W, 24, signed accumulator width per lane (legal range 19 or more).
REQ-004 Parameter N_GROUP, 8, output vectors per layer tile, used for the out_last flag.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port bias, input, N_adder_tree*18, per-lane signed 18-bit bias; lane i in bits [18*(i+1)-1:18*i]; static; driven by the layer bias bank.
REQ-008 Port in_sum, input, N_adder_tree*18, per-lane signed 18-bit adder-tree partial sum, same lane packing.
REQ-009 Port in_valid, input, 1, in_sum is valid.
REQ-010 Port in_ready, output, 1, block accepts in_sum this cycle.
REQ-011 Port out_data, output, N_adder_tree*18, per-lane result after ReLU and saturation, same lane packing.
REQ-012 Port out_valid, output, 1, out_data is valid.
REQ-013 Port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-014 Port out_last, output, 1, high with out_valid on the final vector of each N_GROUP.

Function
REQ-015 A beat SHALL transfer when in_valid && in_ready, and an output SHALL transfer when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready, with no combinational path from in_valid to in_ready.
REQ-017 Pass counter pcnt (0..N_PASS-1) SHALL increment on each accepted beat and wrap to 0 after the beat where pcnt==N_PASS-1.
REQ-018 On an accepted beat with pcnt==0, each lane SHALL load acc = sext(bias) + sext(in_sum).
REQ-019 On an accepted beat with pcnt>0, each lane SHALL update acc = acc + sext(in_sum); the sum SHALL be full-width with no intermediate saturation.
REQ-020 On the accepted beat with pcnt==N_PASS-1, each lane SHALL compute r = the acc value including that beat, then set out_data lane = 0 if r<0, 131071 if r>131071, otherwise r[17:0].
REQ-021 On that same edge out_valid SHALL be set to 1, giving a latency of 1 cycle from the final accepted beat to out_valid.
REQ-022 With N_PASS==1, every accepted beat SHALL produce an output: bias + in_sum, then ReLU and saturation.
REQ-023 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid SHALL clear after an output transfer unless a new final beat is accepted on the same edge; in that case out_valid SHALL stay 1 and carry the new data, sustaining 1 vector per N_PASS cycles.
REQ-025 Group counter gcnt (0..N_GROUP-1) SHALL increment on each output transfer and wrap to 0 after N_GROUP-1.
REQ-026 out_last SHALL equal (gcnt==N_GROUP-1) && out_valid.
REQ-027 Beats not marked valid SHALL leave acc and pcnt unchanged; gaps between beats SHALL be allowed.

Reset
REQ-028 While rst==1 at a clock edge, pcnt, gcnt, out_valid and acc SHALL all clear to 0, and out_data SHALL clear to 0.
REQ-029 When rst==1 and in_valid==1 on the same edge, the beat SHALL be discarded.
REQ-030 A partially accumulated vector SHALL be abandoned on reset, with no output produced.
REQ-031 in_ready SHALL read 1 in the first cycle after reset deasserts.

Verification
REQ-032 Basic path (N_PASS=4, out_ready=1): bias lane0=+4, in_sum lane0 = 10, 20, 30, 40 -> out_data lane0=104 one cycle after the 4th beat, out_valid high for 1 cycle.
REQ-033 ReLU: bias=-1000 and four beats of -5 -> lane output 0.
REQ-034 Saturation: bias=+131071 and four beats of +131071 -> lane output 131071, with no wrap.
REQ-035 Negative wrap guard: four beats of -131072 plus bias -131072 -> output 0.
REQ-036 Backpressure: hold out_ready=0 after an output -> in_ready=0, out_data stable for 10 cycles, no beat lost; then raise out_ready with a final beat pending -> back-to-back outputs with out_valid continuously high.
REQ-037 Reset mid-vector: assert rst after 2 of 4 beats, then send 4 fresh beats -> a single output equal to bias plus the fresh beats only; out_last asserts on the 8th output after reset.
